// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared PRBS polynomial, seed and checker state type for the
//            lfsr generator and the lfsr_checker receiver.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

   localparam int unsigned RND_NUM_W = 16;
   // x^16 + x^14 + x^13 + x^11 + 1, maximal length with a left-shifting register
   localparam logic [RND_NUM_W-1:0] TAPS     = 16'hB400;
   localparam logic [RND_NUM_W-1:0] RND_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      SEEK   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   function automatic logic lfsr_next_bit(input logic [RND_NUM_W-1:0] state);
      return ^(state & TAPS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// ============================================================================
// Module   : lfsr
// Purpose  : Fibonacci PRBS generator; bit_o is the bit shifted into the LSB
//            on the next enabled edge.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr
   import lfsr_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   output logic [RND_NUM_W-1:0] rnd_o,
   output logic                 bit_o
);

   logic [RND_NUM_W-1:0] state_q;
   logic [RND_NUM_W-1:0] state_d;

   always_comb begin
      bit_o   = lfsr_next_bit(state_q);
      state_d = state_q;
      if (en_i) begin
         state_d = {state_q[RND_NUM_W-2:0], bit_o};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RND_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign rnd_o = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Purpose  : Self-synchronising serial PRBS checker with lock detection and
//            a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned LOCK_CNT  = 16,
   parameter int unsigned LOSS_CNT  = 4,
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic                 bit_i,
   input  logic                 clr_i,
   output logic                 locked_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int unsigned FILL_W  = $clog2(RND_NUM_W + 1);
   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned LOSS_W  = $clog2(LOSS_CNT + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(RND_NUM_W - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CNT - 1);

   chk_state_t             state_q,     state_d;
   logic [RND_NUM_W-1:0]   shreg_q,     shreg_d;
   logic [FILL_W-1:0]      fill_cnt_q,  fill_cnt_d;
   logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
   logic [LOSS_W-1:0]      loss_cnt_q,  loss_cnt_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q,   err_cnt_d;
   logic                   err_q,       err_d;
   logic                   locked_q,    locked_d;

   logic pred;
   logic match;
   logic count_err;

   always_comb begin
      pred        = lfsr_next_bit(shreg_q);
      match       = (bit_i == pred);
      state_d     = state_q;
      shreg_d     = shreg_q;
      fill_cnt_d  = fill_cnt_q;
      match_cnt_d = match_cnt_q;
      loss_cnt_d  = loss_cnt_q;
      err_d       = 1'b0;
      count_err   = 1'b0;

      if (valid_i) begin
         case (state_q)
            SEEK: begin
               shreg_d    = {shreg_q[RND_NUM_W-2:0], bit_i};
               fill_cnt_d = fill_cnt_q + FILL_W'(1);
               if (fill_cnt_q == FILL_LAST) begin
                  state_d     = VERIFY;
                  match_cnt_d = '0;
               end
            end

            VERIFY: begin
               shreg_d = {shreg_q[RND_NUM_W-2:0], bit_i};
               // An all-zero register predicts zeros forever, so it never qualifies
               if (match && (shreg_q != '0)) begin
                  match_cnt_d = match_cnt_q + MATCH_W'(1);
                  if (match_cnt_q == MATCH_LAST) begin
                     state_d    = LOCKED;
                     loss_cnt_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end

            LOCKED: begin
               if (match) begin
                  shreg_d    = {shreg_q[RND_NUM_W-2:0], pred};
                  loss_cnt_d = '0;
               end else begin
                  err_d      = 1'b1;
                  count_err  = 1'b1;
                  loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                  if (loss_cnt_q == LOSS_LAST) begin
                     state_d     = SEEK;
                     fill_cnt_d  = '0;
                     match_cnt_d = '0;
                  end else begin
                     shreg_d = {shreg_q[RND_NUM_W-2:0], pred};
                  end
               end
            end

            default: begin
               state_d = SEEK;
            end
         endcase
      end

      err_cnt_d = err_cnt_q;
      if (clr_i) begin
         err_cnt_d = count_err ? ERR_CNT_W'(1) : '0;
      end else if (count_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= SEEK;
         shreg_q     <= '0;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         loss_cnt_q  <= '0;
         err_cnt_q   <= '0;
         err_q       <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         fill_cnt_q  <= fill_cnt_d;
         match_cnt_q <= match_cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_q       <= err_d;
         locked_q    <= locked_d;
      end
   end

   assign locked_o  = locked_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker, the receive end of the `lfsr` random-number generator. It takes the generator's output bitstream one bit per valid cycle and self-synchronises to it by loading its own shift register from received bits. Once locked, it free-runs a local reference, flags every mismatching bit, and keeps a saturating error count. Its job is to verify the generator and any serial path that carries its stream, for example a link test between the board and a host.

## Interface
- `LOCK_CNT`, default 16: consecutive matching bits needed to declare lock.
- `LOSS_CNT`, default 4: consecutive mismatches while locked that drop lock.
- `ERR_CNT_W`, default 16: width of the error counter.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: `bit_i` is meaningful this cycle. All state advances only on `valid_i`.
- `bit_i` in 1: received stream bit. This is the generator's new LSB, `^(state & TAPS)`, in generation order.
- `clr_i` in 1: clear the error counter.
- `locked_o` out 1: checker is in the LOCKED state.
- `err_o` out 1: one-cycle pulse, a mismatch was detected while locked.
- `err_cnt_o` out `ERR_CNT_W`: errors since reset or the last clear, saturating.

Width and taps are `RND_NUM_W` and `TAPS` from `lfsr_pkg`, identical to the generator.

## Operation
- `shreg` holds the last `RND_NUM_W` bits. The predicted bit is `pred = ^(shreg & TAPS)`, and `match = (bit_i == pred)`.
- States are SEEK, VERIFY and LOCKED. All transitions and updates below happen only on cycles with `valid_i`=1. With `valid_i`=0, all state holds and `err_o`=0.
- **SEEK**
  - Shift `bit_i` into `shreg` LSB-first, matching the generator's shift direction. Increment `fill_cnt`.
  - When the `RND_NUM_W`-th bit is loaded, go to VERIFY with `match_cnt`=0.
- **VERIFY**
  - Always shift `bit_i` in. The checker resynchronises on received data.
  - On `match` with `shreg` nonzero: increment `match_cnt`. When it reaches `LOCK_CNT`, go to LOCKED with `loss_cnt`=0.
  - On a mismatch, or when `shreg` is all zero: clear `match_cnt`. An all-zero stream must never lock.
- **LOCKED**
  - Shift `pred` in, not `bit_i`. The reference free-runs, so a single flipped bit counts as exactly one error.
  - On `match`: clear `loss_cnt`.
  - On a mismatch:
    - pulse `err_o`;
    - increment `err_cnt`, saturating at all-ones;
    - increment `loss_cnt`. When it reaches `LOSS_CNT`, go to SEEK with `fill_cnt`=0, `match_cnt`=0 and `shreg` held.
- `err_cnt` is incremented only in LOCKED. Mismatches during SEEK and VERIFY are not errors.
- `clr_i` clears `err_cnt`. If `clr_i` and a counted error occur in the same cycle, `err_cnt` becomes 1. `clr_i` has no effect on state.
- `clr_i` is honoured regardless of `valid_i`.

## Timing
- Reset values: state SEEK, `shreg`=0, all counters 0, `locked_o`=0, `err_o`=0, `err_cnt_o`=0.
- Reset mid-operation drops lock on the next edge.
- All outputs are registered, with one cycle of latency from the deciding `valid_i` beat.
  - `locked_o` rises the cycle after the `LOCK_CNT`-th consecutive qualifying match.
  - `locked_o` falls the cycle after the `LOSS_CNT`-th consecutive mismatch.
  - `err_o` and the `err_cnt_o` update appear the cycle after the erroneous bit.
- Minimum lock time from reset with a clean stream is `RND_NUM_W + LOCK_CNT` valid beats.
- The bit that causes loss of lock is still counted as an error and still pulses `err_o`.
- Counter widths: `fill_cnt` holds `RND_NUM_W`, `match_cnt` holds `LOCK_CNT`, `loss_cnt` holds `LOSS_CNT`. Use `$clog2(N+1)` bits for each.
- Throughput is one bit per clock. There is no backpressure.

## Structure
- Add a `chk_state_t` enum (SEEK, VERIFY, LOCKED) to `lfsr_pkg`.
- Reuse `RND_NUM_W`, `TAPS` and `RND_SEED` from the package. Define no local copies of the polynomial.
- Use a single flat module with no sub-modules. The prediction is the same parity expression as in the generator.
- The testbench instantiates `lfsr` as the stream source and uses its new LSB as `bit_i`.

## Test plan
- **Clean lock:** reset, then drive `lfsr` output with `valid_i`=1 continuously. Required: `locked_o`=1 exactly after `RND_NUM_W+16` beats; `err_cnt_o` stays 0 for 1000 beats.
- **Single error:** once locked, invert one bit. Required: exactly one `err_o` pulse, `err_cnt_o`=1, `locked_o` stays 1, and no further errors on subsequent beats.
- **Loss and relock:** invert 4 consecutive bits. Required: 4 `err_o` pulses, `err_cnt_o`=4, `locked_o` falls after the 4th. The checker then relocks within `RND_NUM_W+16` beats of clean data.
- **Zero stream:** drive `bit_i`=0 with `valid_i`=1 for 500 beats. Required: `locked_o` never asserts and `err_cnt_o`=0.
- **Valid gaps:** insert random `valid_i`=0 cycles, with `bit_i` toggling randomly during the gaps. Required: lock timing is counted in valid beats only, and no errors occur.
- **Clear and saturation:** with `ERR_CNT_W`=4, force 20 isolated errors. Required: `err_cnt_o` stops at 15. Then assert `clr_i` on the same cycle as an error. Required: `err_cnt_o`=1.
